// File: rtl/wm_pkg.sv
// wm_pkg: shared sequencer state codes, water-select bits and phase encoding
package wm_pkg;

    typedef enum logic [2:0] {
        S_OFF, S_IDLE, S_WASH_FILL, S_WASH_AGITATE,
        S_WASH_SPIN, S_RINSE_FILL, S_RINSE_AGITATE, S_RINSE_SPIN
    } seq_state_t;

    localparam int W_HOT  = 1;
    localparam int W_COLD = 0;

    typedef enum logic [2:0] {
        P_IDLE, P_FILL, P_AGITATE, P_DRAIN, P_SPIN, P_DONE, P_FAULT
    } phase_t;

    function automatic phase_t entry_phase(input logic [2:0] s);
        return (s == S_WASH_FILL    || s == S_RINSE_FILL)    ? P_FILL    :
               (s == S_WASH_AGITATE || s == S_RINSE_AGITATE) ? P_AGITATE :
               (s == S_WASH_SPIN    || s == S_RINSE_SPIN)    ? P_DRAIN   : P_IDLE;
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// wm_phase_timer: saturating phase counter with pause and terminal-count flags
module wm_phase_timer #(
    parameter int FILL_TIMEOUT   = 200,
    parameter int AGITATE_CYCLES = 100,
    parameter int REV_PERIOD     = 10,
    parameter int SPIN_CYCLES    = 60,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic fill_tc,
    output logic agit_tc,
    output logic rev_tc,
    output logic spin_tc
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rev;

    // rev tracks cnt mod REV_PERIOD without a divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            rev <= '0;
        end else if (clr) begin
            cnt <= '0;
            rev <= '0;
        end else if (en) begin
            cnt <= (&cnt) ? cnt : cnt + 1'b1;
            rev <= rev_tc ? '0 : rev + 1'b1;
        end
    end

    assign fill_tc = cnt == CNT_W'(FILL_TIMEOUT - 1);
    assign agit_tc = cnt == CNT_W'(AGITATE_CYCLES - 1);
    assign rev_tc  = rev == CNT_W'(REV_PERIOD - 1);
    assign spin_tc = cnt == CNT_W'(SPIN_CYCLES - 1);

endmodule

// File: rtl/wm_phase_driver.sv
// wm_phase_driver: times wash phases and drives valves, pump, motor and door lock
module wm_phase_driver
    import wm_pkg::*;
#(
    parameter int FILL_TIMEOUT   = 200,
    parameter int AGITATE_CYCLES = 100,
    parameter int REV_PERIOD     = 10,
    parameter int SPIN_CYCLES    = 60,
    parameter int CNT_W          = 16
) (
    input  logic       clkorig,
    input  logic       power,
    input  logic [2:0] state_in,
    input  logic [1:0] water_in,
    input  logic       door,
    input  logic       level_full,
    input  logic       level_empty,
    output logic       hot_valve,
    output logic       cold_valve,
    output logic       drain_pump,
    output logic       motor_en,
    output logic       motor_dir,
    output logic       motor_fast,
    output logic       door_lock,
    output logic       phase_done,
    output logic       fault,
    output logic       busy
);
    phase_t     ph, ph_n;
    logic [2:0] prev, prev_n;
    logic       dir, dir_n;
    logic       clr, en, done_n, act, act_n, run_n;
    logic       fill_tc, agit_tc, rev_tc, spin_tc;

    wm_phase_timer #(
        .FILL_TIMEOUT(FILL_TIMEOUT), .AGITATE_CYCLES(AGITATE_CYCLES),
        .REV_PERIOD(REV_PERIOD), .SPIN_CYCLES(SPIN_CYCLES), .CNT_W(CNT_W)
    ) u_timer (
        .clk(clkorig), .rst_n(power), .clr(clr), .en(en),
        .fill_tc(fill_tc), .agit_tc(agit_tc), .rev_tc(rev_tc), .spin_tc(spin_tc)
    );

    always_comb begin
        ph_n   = ph;
        prev_n = prev;
        dir_n  = dir;
        clr    = 1'b0;
        en     = 1'b0;
        done_n = 1'b0;
        act    = ph inside {P_FILL, P_AGITATE, P_DRAIN, P_SPIN};
        if (ph == P_FAULT) begin
            if (state_in == S_OFF) begin
                ph_n   = P_IDLE;
                prev_n = state_in;
                clr    = 1'b1;
            end
        end else if (state_in != prev) begin
            prev_n = state_in;
            clr    = 1'b1;
            dir_n  = 1'b0;
            ph_n   = entry_phase(state_in);
            // a fill is decided on its entry edge when no water is selected or the tub is already full
            if (ph_n == P_FILL && water_in == 2'b00)
                ph_n = P_FAULT;
            else if (ph_n == P_FILL && level_full && !door) begin
                ph_n   = P_DONE;
                done_n = 1'b1;
            end
        end else if (act && !door) begin
            en = 1'b1;
            case (ph)
                P_FILL: begin
                    if (level_full) begin
                        ph_n   = P_DONE;
                        done_n = 1'b1;
                    end else if (fill_tc)
                        ph_n = P_FAULT;
                end
                P_AGITATE: begin
                    if (agit_tc) begin
                        ph_n   = P_DONE;
                        done_n = 1'b1;
                    end else if (rev_tc)
                        dir_n = !dir;
                end
                P_DRAIN: begin
                    if (level_empty) begin
                        ph_n = P_SPIN;
                        clr  = 1'b1;
                    end
                end
                P_SPIN: begin
                    if (spin_tc) begin
                        ph_n   = P_DONE;
                        done_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        act_n = ph_n inside {P_FILL, P_AGITATE, P_DRAIN, P_SPIN};
        run_n = act_n && !door;
    end

    always_ff @(posedge clkorig or negedge power) begin
        if (!power) begin
            ph         <= P_IDLE;
            prev       <= '0;
            dir        <= 1'b0;
            hot_valve  <= 1'b0;
            cold_valve <= 1'b0;
            drain_pump <= 1'b0;
            motor_en   <= 1'b0;
            motor_dir  <= 1'b0;
            motor_fast <= 1'b0;
            door_lock  <= 1'b0;
            phase_done <= 1'b0;
            fault      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ph         <= ph_n;
            prev       <= prev_n;
            dir        <= dir_n;
            hot_valve  <= run_n && ph_n == P_FILL && water_in[W_HOT];
            cold_valve <= run_n && ph_n == P_FILL && water_in[W_COLD];
            drain_pump <= run_n && (ph_n == P_DRAIN || ph_n == P_SPIN);
            motor_en   <= run_n && (ph_n == P_AGITATE || ph_n == P_SPIN);
            motor_dir  <= run_n && ph_n == P_AGITATE && dir_n;
            motor_fast <= run_n && ph_n == P_SPIN;
            door_lock  <= run_n;
            phase_done <= done_n;
            fault      <= ph_n == P_FAULT;
            busy       <= act_n;
        end
    end

endmodule

// File: tb/tb_wm_phase_driver.sv
// tb_wm_phase_driver: directed scenario tests for wm_phase_driver
module tb_wm_phase_driver;
    logic       clkorig = 1'b0;
    logic       power = 1'b0;
    logic [2:0] state_in = '0;
    logic [1:0] water_in = '0;
    logic       door = 1'b0, level_full = 1'b0, level_empty = 1'b0;
    logic       hot_valve, cold_valve, drain_pump, motor_en, motor_dir;
    logic       motor_fast, door_lock, phase_done, fault, busy;
    logic [9:0] outs, exp;
    int         n_cmp = 0, n_err = 0;

    wm_phase_driver dut (
        .clkorig(clkorig), .power(power), .state_in(state_in), .water_in(water_in),
        .door(door), .level_full(level_full), .level_empty(level_empty),
        .hot_valve(hot_valve), .cold_valve(cold_valve), .drain_pump(drain_pump),
        .motor_en(motor_en), .motor_dir(motor_dir), .motor_fast(motor_fast),
        .door_lock(door_lock), .phase_done(phase_done), .fault(fault), .busy(busy)
    );

    always #5 clkorig = ~clkorig;

    // bit order: hot cold pump en dir fast lock done fault busy
    assign outs = {hot_valve, cold_valve, drain_pump, motor_en, motor_dir,
                   motor_fast, door_lock, phase_done, fault, busy};

    task automatic tick(input int n);
        repeat (n) @(posedge clkorig);
        #1;
    endtask

    task automatic do_reset();
        state_in = 3'd0; water_in = 2'b00; door = 0; level_full = 0; level_empty = 0;
        power = 0;
        tick(1);
        power = 1;
        tick(1);
    endtask

    task automatic test_reset();
        power = 0;
        #2;
        exp = 10'b0; n_cmp++;
        if (outs !== exp) begin $display("FAIL reset_hold got %b want %b", outs, exp); n_err++; end
        do_reset();
        n_cmp++;
        if (outs !== exp) begin $display("FAIL reset_release got %b want %b", outs, exp); n_err++; end
    endtask

    task automatic test_hot_fill();
        do_reset();
        water_in = 2'b10; state_in = 3'd2;
        tick(1);
        exp = 10'b1000001001; n_cmp++;
        if (outs !== exp) begin $display("FAIL hot_fill_c0 got %b want %b", outs, exp); n_err++; end
        tick(14);
        n_cmp++;
        if (outs !== exp) begin $display("FAIL hot_fill_c14 got %b want %b", outs, exp); n_err++; end
        level_full = 1;
        tick(1);
        exp = 10'b0000000100; n_cmp++;
        if (outs !== exp) begin $display("FAIL hot_fill_done got %b want %b", outs, exp); n_err++; end
        tick(1);
        exp = 10'b0; n_cmp++;
        if (outs !== exp) begin $display("FAIL hot_fill_after got %b want %b", outs, exp); n_err++; end
        water_in = 2'b01; state_in = 3'd5;
        tick(1);
        exp = 10'b0000000100; n_cmp++;
        if (outs !== exp) begin $display("FAIL full_on_entry got %b want %b", outs, exp); n_err++; end
        tick(1);
        exp = 10'b0; n_cmp++;
        if (outs !== exp) begin $display("FAIL full_on_entry_after got %b want %b", outs, exp); n_err++; end
        level_full = 0;
    endtask

    task automatic test_fill_timeout();
        do_reset();
        water_in = 2'b01; state_in = 3'd5;
        tick(1);
        exp = 10'b0100001001; n_cmp++;
        if (outs !== exp) begin $display("FAIL timeout_c0 got %b want %b", outs, exp); n_err++; end
        tick(199);
        n_cmp++;
        if (outs !== exp) begin $display("FAIL timeout_c199 got %b want %b", outs, exp); n_err++; end
        tick(1);
        exp = 10'b0000000010; n_cmp++;
        if (outs !== exp) begin $display("FAIL timeout_c200 got %b want %b", outs, exp); n_err++; end
        state_in = 3'd6;
        tick(3);
        n_cmp++;
        if (outs !== exp) begin $display("FAIL fault_sticky got %b want %b", outs, exp); n_err++; end
        state_in = 3'd0;
        tick(1);
        exp = 10'b0; n_cmp++;
        if (outs !== exp) begin $display("FAIL fault_clear got %b want %b", outs, exp); n_err++; end
        water_in = 2'b00; state_in = 3'd2;
        tick(1);
        exp = 10'b0000000010; n_cmp++;
        if (outs !== exp) begin $display("FAIL no_water_fault got %b want %b", outs, exp); n_err++; end
        state_in = 3'd0;
        tick(1);
        exp = 10'b0; n_cmp++;
        if (outs !== exp) begin $display("FAIL no_water_clear got %b want %b", outs, exp); n_err++; end
    endtask

    task automatic test_agitate();
        do_reset();
        state_in = 3'd3;
        tick(1);
        exp = 10'b0001001001; n_cmp++;
        if (outs !== exp) begin $display("FAIL agit_c0 got %b want %b", outs, exp); n_err++; end
        tick(9);
        n_cmp++;
        if (outs !== exp) begin $display("FAIL agit_c9 got %b want %b", outs, exp); n_err++; end
        tick(1);
        exp = 10'b0001101001; n_cmp++;
        if (outs !== exp) begin $display("FAIL agit_c10 got %b want %b", outs, exp); n_err++; end
        tick(10);
        exp = 10'b0001001001; n_cmp++;
        if (outs !== exp) begin $display("FAIL agit_c20 got %b want %b", outs, exp); n_err++; end
        tick(79);
        exp = 10'b0001101001; n_cmp++;
        if (outs !== exp) begin $display("FAIL agit_c99 got %b want %b", outs, exp); n_err++; end
        tick(1);
        exp = 10'b0000000100; n_cmp++;
        if (outs !== exp) begin $display("FAIL agit_done got %b want %b", outs, exp); n_err++; end
        tick(1);
        exp = 10'b0; n_cmp++;
        if (outs !== exp) begin $display("FAIL agit_after got %b want %b", outs, exp); n_err++; end
        state_in = 3'd4;
        tick(1);
        exp = 10'b0010001001; n_cmp++;
        if (outs !== exp) begin $display("FAIL drain_c0 got %b want %b", outs, exp); n_err++; end
        level_empty = 1;
        tick(1);
        exp = 10'b0011011001; n_cmp++;
        if (outs !== exp) begin $display("FAIL spin_c0 got %b want %b", outs, exp); n_err++; end
        level_empty = 0;
        tick(59);
        n_cmp++;
        if (outs !== exp) begin $display("FAIL spin_c59 got %b want %b", outs, exp); n_err++; end
        tick(1);
        exp = 10'b0000000100; n_cmp++;
        if (outs !== exp) begin $display("FAIL spin_done got %b want %b", outs, exp); n_err++; end
    endtask

    task automatic test_door_pause();
        do_reset();
        state_in = 3'd6;
        tick(41);
        exp = 10'b0001001001; n_cmp++;
        if (outs !== exp) begin $display("FAIL door_c40 got %b want %b", outs, exp); n_err++; end
        door = 1;
        tick(1);
        exp = 10'b0000000001; n_cmp++;
        if (outs !== exp) begin $display("FAIL door_open got %b want %b", outs, exp); n_err++; end
        tick(19);
        n_cmp++;
        if (outs !== exp) begin $display("FAIL door_c60 got %b want %b", outs, exp); n_err++; end
        door = 0;
        tick(1);
        exp = 10'b0001001001; n_cmp++;
        if (outs !== exp) begin $display("FAIL door_resume got %b want %b", outs, exp); n_err++; end
        tick(58);
        exp = 10'b0001101001; n_cmp++;
        if (outs !== exp) begin $display("FAIL door_c119 got %b want %b", outs, exp); n_err++; end
        tick(1);
        exp = 10'b0000000100; n_cmp++;
        if (outs !== exp) begin $display("FAIL door_done_c120 got %b want %b", outs, exp); n_err++; end
    endtask

    task automatic test_drain_spin();
        do_reset();
        door = 1; state_in = 3'd7;
        tick(1);
        exp = 10'b0000000001; n_cmp++;
        if (outs !== exp) begin $display("FAIL entry_paused got %b want %b", outs, exp); n_err++; end
        door = 0;
        tick(1);
        exp = 10'b0010001001; n_cmp++;
        if (outs !== exp) begin $display("FAIL drain_resume got %b want %b", outs, exp); n_err++; end
        tick(6);
        n_cmp++;
        if (outs !== exp) begin $display("FAIL drain_c7 got %b want %b", outs, exp); n_err++; end
        level_empty = 1;
        tick(1);
        exp = 10'b0011011001; n_cmp++;
        if (outs !== exp) begin $display("FAIL spin_start got %b want %b", outs, exp); n_err++; end
        tick(59);
        n_cmp++;
        if (outs !== exp) begin $display("FAIL spin_last got %b want %b", outs, exp); n_err++; end
        state_in = 3'd1;
        tick(1);
        exp = 10'b0; n_cmp++;
        if (outs !== exp) begin $display("FAIL change_at_done got %b want %b", outs, exp); n_err++; end
        level_empty = 0;
    endtask

    task automatic test_reset_mid_spin();
        do_reset();
        state_in = 3'd4; level_empty = 1;
        tick(3);
        exp = 10'b0011011001; n_cmp++;
        if (outs !== exp) begin $display("FAIL pre_reset_spin got %b want %b", outs, exp); n_err++; end
        #2 power = 0;
        #1;
        exp = 10'b0; n_cmp++;
        if (outs !== exp) begin $display("FAIL async_reset got %b want %b", outs, exp); n_err++; end
        state_in = 3'd1; level_empty = 0;
        tick(1);
        power = 1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_cmp++;
            if (outs !== exp) begin $display("FAIL idle_after_reset[%0d] got %b want %b", i, outs, exp); n_err++; end
        end
    endtask

    initial begin
        test_reset();
        test_hot_fill();
        test_fill_timeout();
        test_agitate();
        test_door_pause();
        test_drain_spin();
        test_reset_mid_spin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
